// File: rtl/kara_combine_acc.sv
// Karatsuba recombination of 4x4 nibble partial products into 8x8 products,
// accumulated per frame and reported with beat count, overflow and error flags.
module kara_combine_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       pp_hi,
  input  logic [7:0]       pp_lo,
  input  logic [9:0]       pp_mid,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic             out_err
);

  // Cross term A1*B0 + A0*B1; modulo-512 arithmetic keeps the low 9 bits exact.
  function automatic logic [8:0] cross_term(input logic [9:0] mid,
                                            input logic [7:0] hi,
                                            input logic [7:0] lo,
                                            input logic       bad);
    logic [8:0] diff;
    diff = mid[8:0] - {1'b0, hi} - {1'b0, lo};
    return bad ? 9'd0 : diff;
  endfunction

  // The 17-bit sum is only ever kept to 16 bits, so form it at 16 directly.
  function automatic logic [15:0] recombine(input logic [7:0] hi,
                                            input logic [8:0] mid,
                                            input logic [7:0] lo);
    return {hi, 8'd0} + {3'd0, mid, 4'd0} + {8'd0, lo};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hff) ? 8'hff : c + 8'd1;
  endfunction

  logic             pipe_en;
  logic [9:0]       hl_sum;
  logic             mid_bad;

  logic             vld_p1;
  logic             last_p1;
  logic             err_p1;
  logic [7:0]       hi_p1;
  logic [7:0]       lo_p1;
  logic [8:0]       mid_p1;

  logic             vld_p2;
  logic             last_p2;
  logic             err_p2;
  logic [15:0]      prod_p2;

  logic [ACC_W-1:0] acc;
  logic [7:0]       count;
  logic             ovf;
  logic             err;

  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_nxt;
  logic [7:0]       count_nxt;
  logic             ovf_nxt;
  logic             err_nxt;

  // A pending result that downstream has not taken freezes the whole pipe.
  assign pipe_en  = !(out_valid && !out_ready);
  assign in_ready = pipe_en;

  assign hl_sum  = {2'd0, pp_hi} + {2'd0, pp_lo};
  assign mid_bad = (pp_mid < hl_sum);

  // ---- stage p1: cross-term extraction ----
  always_ff @(posedge clk) begin
    if (pipe_en && in_valid) begin
      hi_p1   <= pp_hi;
      lo_p1   <= pp_lo;
      mid_p1  <= cross_term(pp_mid, pp_hi, pp_lo, mid_bad);
      last_p1 <= in_last;
      err_p1  <= mid_bad;
    end
  end

  // ---- stage p2: product recombination ----
  always_ff @(posedge clk) begin
    if (pipe_en && vld_p1) begin
      prod_p2 <= recombine(hi_p1, mid_p1, lo_p1);
      last_p2 <= last_p1;
      err_p2  <= err_p1;
    end
  end

  always_comb begin
    acc_sum   = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod_p2};
    acc_nxt   = acc_sum[ACC_W-1:0];
    count_nxt = sat_inc(count);
    ovf_nxt   = ovf | acc_sum[ACC_W];
    err_nxt   = err | err_p2;
  end

  // ---- stage p3: frame accumulation and result register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      acc       <= '0;
      count     <= 8'd0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= 8'd0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (pipe_en) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2 && last_p2;
      if (vld_p2) begin
        if (last_p2) begin
          out_sum   <= acc_nxt;
          out_count <= count_nxt;
          out_ovf   <= ovf_nxt;
          out_err   <= err_nxt;
          acc       <= '0;
          count     <= 8'd0;
          ovf       <= 1'b0;
          err       <= 1'b0;
        end else begin
          acc       <= acc_nxt;
          count     <= count_nxt;
          ovf       <= ovf_nxt;
          err       <= err_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_kara_combine_acc.sv
// Directed bench for kara_combine_acc: default 24-bit accumulator plus an
// 18-bit instance sharing the same stimulus for the wraparound case.
module tb_kara_combine_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  pp_hi;
  logic [7:0]  pp_lo;
  logic [9:0]  pp_mid;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a, out_err_a;
  logic [23:0] out_sum_a;
  logic [7:0]  out_count_a;

  logic        in_ready_b, out_valid_b, out_ovf_b, out_err_b;
  logic [17:0] out_sum_b;
  logic [7:0]  out_count_b;

  int tests = 0;
  int fails = 0;

  kara_combine_acc #(.ACC_W(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .pp_hi(pp_hi), .pp_lo(pp_lo), .pp_mid(pp_mid), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
    .out_count(out_count_a), .out_ovf(out_ovf_a), .out_err(out_err_a)
  );

  kara_combine_acc #(.ACC_W(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .pp_hi(pp_hi), .pp_lo(pp_lo), .pp_mid(pp_mid), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
    .out_count(out_count_b), .out_ovf(out_ovf_b), .out_err(out_err_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] hi, input logic [7:0] lo,
                      input logic [9:0] mid, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    pp_hi    = hi;
    pp_lo    = lo;
    pp_mid   = mid;
    in_last  = last;
    while (!in_ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_a) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    pp_hi     = 8'd0;
    pp_lo     = 8'd0;
    pp_mid    = 10'd0;
    out_ready = 1'b1;

    #1;
    check_val("rst_out_valid", 32'(out_valid_a), 32'd0);
    check_val("rst_in_ready", 32'(in_ready_a), 32'd1);
    check_val("rst_out_sum", 32'(out_sum_a), 32'd0);
    check_val("rst_out_count", 32'(out_count_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", 32'(in_ready_a), 32'd1);

    // single beat, latency of three edges
    send(8'd0, 8'd120, 10'd285, 1'b1);
    @(negedge clk);
    check_val("lat_edge1", 32'(out_valid_a), 32'd0);
    @(negedge clk);
    check_val("lat_edge2", 32'(out_valid_a), 32'd0);
    @(negedge clk);
    check_val("lat_edge3", 32'(out_valid_a), 32'd1);
    check_val("single_sum", 32'(out_sum_a), 32'd2760);
    check_val("single_count", 32'(out_count_a), 32'd1);
    check_val("single_ovf", 32'(out_ovf_a), 32'd0);
    check_val("single_err", 32'(out_err_a), 32'd0);
    @(negedge clk);
    check_val("valid_clears", 32'(out_valid_a), 32'd0);

    // two full-scale beats
    send(8'd225, 8'd225, 10'd900, 1'b0);
    send(8'd225, 8'd225, 10'd900, 1'b1);
    wait_out("two");
    check_val("two_sum", 32'(out_sum_a), 32'd130050);
    check_val("two_count", 32'(out_count_a), 32'd2);
    check_val("two_ovf", 32'(out_ovf_a), 32'd0);

    // five beats: wraps the 18-bit accumulator
    for (int i = 0; i < 4; i++) send(8'd225, 8'd225, 10'd900, 1'b0);
    send(8'd225, 8'd225, 10'd900, 1'b1);
    wait_out("five");
    check_val("five_b_valid", 32'(out_valid_b), 32'd1);
    check_val("five_b_sum", 32'(out_sum_b), 32'd62981);
    check_val("five_b_ovf", 32'(out_ovf_b), 32'd1);
    check_val("five_b_count", 32'(out_count_b), 32'd5);
    check_val("five_a_sum", 32'(out_sum_a), 32'd325125);
    check_val("five_a_ovf", 32'(out_ovf_a), 32'd0);

    // inconsistent middle product
    send(8'd1, 8'd1, 10'd0, 1'b1);
    wait_out("err");
    check_val("err_flag", 32'(out_err_a), 32'd1);
    check_val("err_sum", 32'(out_sum_a), 32'd257);
    check_val("err_count", 32'(out_count_a), 32'd1);
    @(negedge clk);

    // backpressure with a second frame queued behind the pending result
    out_ready = 1'b0;
    send(8'd0, 8'd120, 10'd285, 1'b1);
    send(8'd225, 8'd225, 10'd900, 1'b0);
    send(8'd1, 8'd1, 10'd0, 1'b1);
    @(negedge clk);
    check_val("stall_in_ready", 32'(in_ready_a), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check_val("stall_valid", 32'(out_valid_a), 32'd1);
      check_val("stall_sum", 32'(out_sum_a), 32'd2760);
      check_val("stall_count", 32'(out_count_a), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val("release_clears", 32'(out_valid_a), 32'd0);
    wait_out("release");
    check_val("release_sum", 32'(out_sum_a), 32'd65282);
    check_val("release_count", 32'(out_count_a), 32'd2);
    check_val("release_err", 32'(out_err_a), 32'd1);
    @(negedge clk);

    // reset mid-frame discards the partial frame
    send(8'd225, 8'd225, 10'd900, 1'b0);
    send(8'd225, 8'd225, 10'd900, 1'b0);
    rst_n = 1'b0;
    #2;
    check_val("midrst_valid", 32'(out_valid_a), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready_a), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("midrst_no_result", 32'(out_valid_a), 32'd0);
    send(8'd0, 8'd120, 10'd285, 1'b1);
    wait_out("after_rst");
    check_val("after_rst_sum", 32'(out_sum_a), 32'd2760);
    check_val("after_rst_count", 32'(out_count_a), 32'd1);
    check_val("after_rst_ovf", 32'(out_ovf_a), 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
